// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment scan controller: glyph table,
// blank segment pattern and parameter sanity helpers.
package sseg_pkg;

  localparam logic [6:0] SEG_OFF    = 7'h7F;
  localparam int         MAX_DIGITS = 8;

  // Active-low glyphs {g,f,e,d,c,b,a} for nibble values 0..F
  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic bit digits_ok(input int n);
    return (n >= 1) && (n <= MAX_DIGITS);
  endfunction

  function automatic bit slot_ok(input int slot_cyc, input int guard_cyc);
    return (guard_cyc >= 0) && (slot_cyc > guard_cyc);
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Nibble to active-low seven-segment glyph lookup (combinational).
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Straight table lookup into the shared glyph array
  always_comb begin
    seg = GLYPH[nib];
  end

endmodule

// File: rtl/sseg_scan_mux.sv
// N-digit multiplexed seven-segment scan controller with frame-coherent
// input latching, blanking, leading-zero suppression, guard time and PWM.
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int SLOT_CYC  = 100000,
  parameter int GUARD_CYC = 4,
  parameter int DIM_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   hex,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  lz_sup,
  input  logic [DIM_BITS-1:0]   bright,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            sseg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int S_W = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int D_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [S_W-1:0] S_LAST  = S_W'(SLOT_CYC - 1);
  localparam logic [S_W-1:0] S_GUARD = S_W'(GUARD_CYC);
  localparam logic [D_W-1:0] D_LAST  = D_W'(DIGITS - 1);

  generate
    if (!digits_ok(DIGITS)) begin : g_bad_digits
      $error("sseg_scan_mux: DIGITS must be in 1..8");
    end
    if (!slot_ok(SLOT_CYC, GUARD_CYC)) begin : g_bad_slot
      $error("sseg_scan_mux: SLOT_CYC must exceed GUARD_CYC");
    end
  endgenerate

  logic [S_W-1:0]      s;
  logic [D_W-1:0]      d;
  logic [DIM_BITS-1:0] p;

  logic [4*DIGITS-1:0] hex_sh;
  logic [DIGITS-1:0]   dp_sh;
  logic [DIGITS-1:0]   blank_sh;
  logic                lz_sh;

  logic                is_fs;
  logic [4*DIGITS-1:0] hex_eff;
  logic [DIGITS-1:0]   dp_eff;
  logic [DIGITS-1:0]   blank_eff;
  logic                lz_eff;
  logic [DIGITS-1:0]   sup;
  logic [3:0]          nib_sel;
  logic                dp_sel;
  logic                dark_sel;
  logic                pwm_ok;
  logic                lit;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_dec;

  // The frame-start cycle displays the values being captured that same edge,
  // so the whole frame sees one coherent snapshot.
  assign is_fs     = en && (s == '0) && (d == '0);
  assign hex_eff   = is_fs ? hex    : hex_sh;
  assign dp_eff    = is_fs ? dp_in  : dp_sh;
  assign blank_eff = is_fs ? blank  : blank_sh;
  assign lz_eff    = is_fs ? lz_sup : lz_sh;

  assign pwm_ok = (bright == '1) || (p < bright);
  assign lit    = en && (s >= S_GUARD) && pwm_ok && !dark_sel;

  // Slot, digit and PWM counters; all parked at zero while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
      d <= '0;
      p <= '0;
    end else if (!en) begin
      s <= '0;
      d <= '0;
      p <= '0;
    end else begin
      p <= p + 1'b1;
      if (s == S_LAST) begin
        s <= '0;
        d <= (d == D_LAST) ? '0 : d + 1'b1;
      end else begin
        s <= s + 1'b1;
      end
    end
  end

  // Shadow copy of the display inputs, refreshed only at frame start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hex_sh   <= '0;
      dp_sh    <= '0;
      blank_sh <= '0;
      lz_sh    <= 1'b0;
    end else if (is_fs) begin
      hex_sh   <= hex;
      dp_sh    <= dp_in;
      blank_sh <= blank;
      lz_sh    <= lz_sup;
    end
  end

  // Leading-zero suppression chain from the most significant digit down
  always_comb begin
    logic chain;
    sup   = '0;
    chain = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      sup[i] = lz_eff && (hex_eff[4*i +: 4] == 4'h0) && !dp_eff[i] && chain;
      chain  = sup[i] || blank_eff[i];
    end
  end

  // Pick the nibble, dp request and darkness of the digit being scanned
  always_comb begin
    nib_sel  = 4'h0;
    dp_sel   = 1'b0;
    dark_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (d == D_W'(i)) begin
        nib_sel  = hex_eff[4*i +: 4];
        dp_sel   = dp_eff[i];
        dark_sel = blank_eff[i] || sup[i];
      end
    end
  end

  // One-hot active-low anode pattern for the scanned digit
  always_comb begin
    an_next = '1;
    for (int i = 0; i < DIGITS; i++) begin
      an_next[i] = !(lit && (d == D_W'(i)));
    end
  end

  sseg_hex_decode u_decode (
    .nib (nib_sel),
    .seg (seg_dec)
  );

  // Registered pin drivers so the board sees glitch-free levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an          <= '1;
      sseg        <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= an_next;
      sseg        <= lit ? seg_dec : SEG_OFF;
      dp          <= lit ? !dp_sel : 1'b1;
      frame_start <= is_fs;
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed self-checking bench for sseg_scan_mux (4 digits, 16-cycle slots).
module tb_sseg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] hex;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        lz_sup;
  logic [3:0]  bright;
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  sseg_scan_mux #(
    .DIGITS    (4),
    .SLOT_CYC  (16),
    .GUARD_CYC (2),
    .DIM_BITS  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .hex         (hex),
    .dp_in       (dp_in),
    .blank       (blank),
    .lz_sup      (lz_sup),
    .bright      (bright),
    .an          (an),
    .sseg        (sseg),
    .dp          (dp),
    .frame_start (frame_start)
  );

  // 10-time-unit system clock
  always #5 clk = ~clk;

  // Expected {an,sseg,dp,frame_start} at output cycle k of a frame.
  // segs packs glyphs {d3,d2,d1,d0}; pmask bit n = PWM permits at slot cycle n
  // (the PWM counter equals the slot cycle while enable stays high).
  function automatic logic [12:0] exp_vec(input int k, input logic [27:0] segs,
                                          input logic [3:0] dark, input logic [3:0] dps,
                                          input logic [15:0] pmask);
    int dg, sl;
    logic on;
    logic [3:0] a;
    dg = k / 16;
    sl = k % 16;
    on = (sl >= 2) && pmask[sl] && !dark[dg];
    a  = 4'hF;
    if (on) a[dg] = 1'b0;
    return {a, (on ? segs[7*dg +: 7] : 7'h7F), (on ? ~dps[dg] : 1'b1), (k == 0)};
  endfunction

  // Advance at least one cycle, then stop on the next frame_start (bounded)
  task automatic wait_frame;
    int n;
    n = 0;
    @(negedge clk);
    while (frame_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL frame_timeout: frame_start=%b required 1", frame_start);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; hex = '0; dp_in = '0; blank = '0;
    lz_sup = 1'b0; bright = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if ({an, sseg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_values: got %h required %h", {an, sseg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({an, sseg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL disabled_dark: got %h required %h", {an, sseg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
  endtask

  task automatic test_basic;
    logic [12:0] e;
    hex = 16'h1234; en = 1'b1;
    wait_frame();
    for (int k = 0; k < 64; k++) begin
      e = exp_vec(k, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 4'b0000, 16'hFFFF);
      checks++;
      if ({an, sseg, dp, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL basic k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, e);
      end
      @(negedge clk);
    end
    checks++;
    if (frame_start !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_period: frame_start=%b required 1", frame_start);
    end
  endtask

  task automatic test_lz;
    logic [12:0] e;
    hex = 16'h0050; lz_sup = 1'b1; dp_in = 4'b0000;
    wait_frame();
    for (int k = 0; k < 64; k++) begin
      e = exp_vec(k, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1100, 4'b0000, 16'hFFFF);
      checks++;
      if ({an, sseg, dp, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL lz k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, e);
      end
      @(negedge clk);
    end
    dp_in = 4'b0100;
    wait_frame();
    for (int k = 0; k < 64; k++) begin
      e = exp_vec(k, {7'h7F, 7'h40, 7'h12, 7'h40}, 4'b1000, 4'b0100, 16'hFFFF);
      checks++;
      if ({an, sseg, dp, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL lz_dp k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, e);
      end
      @(negedge clk);
    end
    lz_sup = 1'b0; dp_in = 4'b0000;
  endtask

  task automatic test_shadow;
    logic [12:0] e;
    hex = 16'h1111;
    wait_frame();
    for (int k = 0; k < 64; k++) begin
      e = exp_vec(k, {4{7'h79}}, 4'b0000, 4'b0000, 16'hFFFF);
      checks++;
      if ({an, sseg, dp, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL shadow_old k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, e);
      end
      if (k == 20) hex = 16'h2222;
      @(negedge clk);
    end
    for (int k = 0; k < 32; k++) begin
      e = exp_vec(k, {4{7'h24}}, 4'b0000, 4'b0000, 16'hFFFF);
      checks++;
      if ({an, sseg, dp, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL shadow_new k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_blank;
    logic [12:0] e;
    hex = 16'h1234; blank = 4'b0100;
    wait_frame();
    for (int k = 0; k < 64; k++) begin
      e = exp_vec(k, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0100, 4'b0000, 16'hFFFF);
      checks++;
      if ({an, sseg, dp, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL blank k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, e);
      end
      @(negedge clk);
    end
    blank = 4'b0000;
  endtask

  task automatic test_pwm;
    logic [12:0] e;
    int lows;
    bright = 4'd4;
    wait_frame();
    lows = 0;
    for (int k = 0; k < 64; k++) begin
      e = exp_vec(k, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, 4'b0000, 16'h000F);
      checks++;
      if ({an, sseg, dp, frame_start} !== e) begin
        errors++;
        $display("[TB] FAIL pwm4 k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, e);
      end
      if (an !== 4'hF) lows++;
      @(negedge clk);
    end
    checks++;
    if (lows != 8) begin
      errors++;
      $display("[TB] FAIL pwm4_count: lit cycles=%0d required 8", lows);
    end
    bright = 4'd0;
    wait_frame();
    lows = 0;
    for (int k = 0; k < 64; k++) begin
      if (an !== 4'hF) lows++;
      @(negedge clk);
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("[TB] FAIL pwm0_count: lit cycles=%0d required 0", lows);
    end
    bright = 4'hF;
  endtask

  task automatic test_enable;
    wait_frame();
    repeat (5) @(negedge clk);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({an, sseg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        errors++;
        $display("[TB] FAIL en_low k=%0d: got %h required %h", k, {an, sseg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
      end
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, frame_start} !== {4'hF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL en_restart: an/fs=%b_%b required 1111_1", an, frame_start);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({an, sseg} !== {4'b1110, 7'h19}) begin
      errors++;
      $display("[TB] FAIL en_first_digit: an=%b sseg=%h required 1110 19", an, sseg);
    end
  endtask

  task automatic test_midreset;
    wait_frame();
    repeat (5) @(negedge clk);
    checks++;
    if (an !== 4'b1110) begin
      errors++;
      $display("[TB] FAIL pre_reset_lit: an=%b required 1110", an);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, sseg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h required %h", {an, sseg, dp, frame_start}, {4'hF, 7'h7F, 1'b1, 1'b0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({an, frame_start} !== {4'hF, 1'b1}) begin
      errors++;
      $display("[TB] FAIL post_reset_fs: an/fs=%b_%b required 1111_1", an, frame_start);
    end
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_basic();
    test_lz();
    test_shadow();
    test_blank();
    test_pwm();
    test_enable();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
